// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU ops combinationally in IDLE; MUL/MULHU via a 32-step shift-add FSM.
// Multiply latency: accept, 33 MUL cycles, one DONE cycle; in_ready is low for all 34 busy cycles.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  rd_in,
    input  logic        regwrite_in,
    output logic        out_valid,
    output logic [31:0] alu_y,
    output logic [4:0]  rd_out,
    output logic        regwrite_out,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_op;
    logic [4:0]  r_rd;
    logic        r_rw;
    logic [63:0] r_prod;
    logic [5:0]  r_cnt;

    logic        w_is_mul;
    logic        w_single;
    logic        w_done;
    logic        w_rw;
    logic [31:0] w_alu;
    logic [31:0] w_mul_y;

    assign w_is_mul = (op == 4'd10) || (op == 4'd11);

    always_comb begin
        w_alu = 32'd0;
        case (op)
            4'd0:    w_alu = a + b;
            4'd1:    w_alu = a - b;
            4'd2:    w_alu = a & b;
            4'd3:    w_alu = a | b;
            4'd4:    w_alu = a ^ b;
            4'd5:    w_alu = a << b[4:0];
            4'd6:    w_alu = a >> b[4:0];
            4'd7:    w_alu = $unsigned($signed(a) >>> b[4:0]);
            4'd8:    w_alu = {31'd0, $signed(a) < $signed(b)};
            4'd9:    w_alu = {31'd0, a < b};
            default: w_alu = 32'd0;
        endcase
    end

    // Flush and reset both turn the current cycle into a bubble.
    assign w_single  = (r_state == S_IDLE) && in_valid && !w_is_mul && !flush;
    assign w_done    = (r_state == S_DONE) && !flush;
    assign out_valid = !rst && (w_single || w_done);
    assign w_mul_y   = (r_op == 4'd11) ? r_prod[63:32] : r_prod[31:0];
    assign w_rw      = w_single ? regwrite_in : r_rw;

    assign alu_y        = !out_valid ? 32'd0 : (w_single ? w_alu : w_mul_y);
    assign rd_out       = !out_valid ? 5'd0  : (w_single ? rd_in : r_rd);
    assign regwrite_out = out_valid && w_rw && (rd_out != 5'd0);
    assign in_ready     = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 4'd0;
            r_rd    <= 5'd0;
            r_rw    <= 1'b0;
            r_prod  <= 64'd0;
            r_cnt   <= 6'd0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && w_is_mul) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_rd    <= rd_in;
                        r_rw    <= regwrite_in;
                        r_prod  <= 64'd0;
                        r_cnt   <= 6'd0;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    // Iteration i adds a<<i when multiplier bit i is set.
                    if (r_cnt == 6'd32) begin
                        r_state <= S_DONE;
                    end else begin
                        if (r_b[r_cnt[4:0]])
                            r_prod <= r_prod + ({32'd0, r_a} << r_cnt);
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: single-cycle op table plus multiply, flush and reset sequences.
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        regwrite_in;
    logic        out_valid;
    logic [31:0] alu_y;
    logic [4:0]  rd_out;
    logic        regwrite_out;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    exe_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .op           (op),
        .a            (a),
        .b            (b),
        .rd_in        (rd_in),
        .regwrite_in  (regwrite_in),
        .out_valid    (out_valid),
        .alu_y        (alu_y),
        .rd_out       (rd_out),
        .regwrite_out (regwrite_out),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] y;
        logic        rw_out;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] rd, input logic rw);
        in_valid    = 1'b1;
        op          = o;
        a           = x;
        b           = y;
        rd_in       = rd;
        regwrite_in = rw;
    endtask

    // Accept a multiply; returns at the negedge of the first MUL cycle.
    task automatic start_mul(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [4:0] rd);
        @(negedge clk);
        drive(o, x, y, rd, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Runs a multiply to completion; returns at negedge+1 of the first IDLE cycle.
    task automatic do_mul(input string nm, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] rd, input logic rw,
                          input logic [31:0] exp_y, input logic exp_rw, input bit noise);
        int nbusy;
        int pulses;
        logic [31:0] got_y;
        logic [4:0]  got_rd;
        logic        got_rw;
        nbusy = 0; pulses = 0; got_y = '0; got_rd = '0; got_rw = 1'b0;
        @(negedge clk);
        drive(o, x, y, rd, rw);
        #1;
        chk({nm, "_accept_ov"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_accept_rdy"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        // Upstream presenting a different instruction while busy must be ignored.
        if (noise) drive(4'd0, 32'd100, 32'd1, 5'd9, 1'b1);
        else in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (in_ready) break;
            nbusy++;
            if (out_valid) begin
                pulses++;
                got_y  = alu_y;
                got_rd = rd_out;
                got_rw = regwrite_out;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk({nm, "_busy_cycles"}, nbusy, 34);
        chk({nm, "_pulses"}, pulses, 1);
        chk({nm, "_y"}, got_y, exp_y);
        chk({nm, "_rd"}, {27'd0, got_rd}, {27'd0, rd});
        chk({nm, "_rw"}, {31'd0, got_rw}, {31'd0, exp_rw});
    endtask

    initial begin
        int pulses;
        int notrdy;
        bit found;

        //             name        op     a             b             rd     rw    y             rw_out
        vecs[0]  = '{"add",       4'd0,  32'd5,        32'd7,        5'd3,  1'b1, 32'd12,       1'b1};
        vecs[1]  = '{"sub",       4'd1,  32'd3,        32'd5,        5'd4,  1'b1, 32'hFFFFFFFE, 1'b1};
        vecs[2]  = '{"add_wrap",  4'd0,  32'hFFFFFFFF, 32'd1,        5'd4,  1'b1, 32'd0,        1'b1};
        vecs[3]  = '{"and",       4'd2,  32'hF0F0FF00, 32'h0FF0F0F0, 5'd1,  1'b1, 32'h00F0F000, 1'b1};
        vecs[4]  = '{"or",        4'd3,  32'hF0000000, 32'h0000000F, 5'd1,  1'b1, 32'hF000000F, 1'b1};
        vecs[5]  = '{"xor",       4'd4,  32'hFF00FF00, 32'h0FF00FF0, 5'd2,  1'b1, 32'hF0F0F0F0, 1'b1};
        vecs[6]  = '{"sll",       4'd5,  32'd1,        32'h21,       5'd2,  1'b1, 32'd2,        1'b1};
        vecs[7]  = '{"srl",       4'd6,  32'h80000000, 32'h24,       5'd2,  1'b1, 32'h08000000, 1'b1};
        vecs[8]  = '{"sra",       4'd7,  32'h80000000, 32'h24,       5'd8,  1'b1, 32'hF8000000, 1'b1};
        vecs[9]  = '{"slt",       4'd8,  32'hFFFFFFFF, 32'd1,        5'd8,  1'b1, 32'd1,        1'b1};
        vecs[10] = '{"sltu",      4'd9,  32'hFFFFFFFF, 32'd1,        5'd8,  1'b1, 32'd0,        1'b1};
        vecs[11] = '{"slt_pos",   4'd8,  32'd5,        32'hFFFFFFFD, 5'd8,  1'b1, 32'd0,        1'b1};
        vecs[12] = '{"sltu_lt",   4'd9,  32'd1,        32'hFFFFFFFF, 5'd8,  1'b1, 32'd1,        1'b1};
        vecs[13] = '{"reserved",  4'd12, 32'd5,        32'd7,        5'd4,  1'b1, 32'd0,        1'b1};
        vecs[14] = '{"add_rd0",   4'd0,  32'd5,        32'd7,        5'd0,  1'b1, 32'd12,       1'b0};
        vecs[15] = '{"add_norw",  4'd0,  32'd5,        32'd7,        5'd7,  1'b0, 32'd12,       1'b0};

        rst = 1'b1;
        flush = 1'b0;
        drive(4'd0, 32'd5, 32'd7, 5'd3, 1'b1);
        @(negedge clk);
        #1;
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_y", alu_y, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        chk("rst_rw", {31'd0, regwrite_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].rw);
            #1;
            chk({vecs[i].name, "_ov"}, {31'd0, out_valid}, 32'd1);
            chk({vecs[i].name, "_y"}, alu_y, vecs[i].y);
            chk({vecs[i].name, "_rd"}, {27'd0, rd_out}, {27'd0, vecs[i].rd});
            chk({vecs[i].name, "_rw"}, {31'd0, regwrite_out}, {31'd0, vecs[i].rw_out});
            chk({vecs[i].name, "_rdy"}, {31'd0, in_ready}, 32'd1);
        end

        // Bubble: operands still present but in_valid low.
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bubble_ov", {31'd0, out_valid}, 32'd0);
        chk("bubble_y", alu_y, 32'd0);
        chk("bubble_rd", {27'd0, rd_out}, 32'd0);
        chk("bubble_rw", {31'd0, regwrite_out}, 32'd0);

        do_mul("mul", 4'd10, 32'hFFFFFFFF, 32'd2, 5'd5, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0);
        // Back-to-back: first IDLE cycle after DONE takes a new instruction.
        drive(4'd0, 32'd20, 32'd22, 5'd6, 1'b1);
        #1;
        chk("b2b_ov", {31'd0, out_valid}, 32'd1);
        chk("b2b_y", alu_y, 32'd42);
        in_valid = 1'b0;
        do_mul("mulhu", 4'd11, 32'hFFFFFFFF, 32'd2, 5'd5, 1'b1, 32'h00000001, 1'b1, 1'b1);
        do_mul("mulhu_max", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0);
        do_mul("mul_rd0", 4'd10, 32'd12345, 32'd1000, 5'd0, 1'b1, 32'h00BC5EA8, 1'b0, 1'b0);

        // Flush in MUL cycle 10.
        start_mul(4'd10, 32'd3, 32'd4, 5'd6);
        pulses = 0;
        for (int i = 1; i < 10; i++) begin
            #1;
            if (out_valid) pulses++;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        chk("flush_mul_ov", {31'd0, out_valid}, 32'd0);
        chk("flush_mul_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_mul_rdy", {31'd0, in_ready}, 32'd1);
        drive(4'd0, 32'd1, 32'd1, 5'd2, 1'b1);
        #1;
        chk("flush_add_y", alu_y, 32'd2);
        chk("flush_add_ov", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (out_valid) pulses++;
            @(negedge clk);
        end
        chk("flush_mul_pulses", pulses, 0);

        // Flush during the DONE cycle itself.
        start_mul(4'd11, 32'hFFFFFFFF, 32'd2, 5'd5);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("flush_done_reached", {31'd0, found}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_done_ov", {31'd0, out_valid}, 32'd0);
        chk("flush_done_y", alu_y, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_done_rdy", {31'd0, in_ready}, 32'd1);

        // Flush in IDLE blocks acceptance of a multiply and suppresses a single-cycle op.
        @(negedge clk);
        drive(4'd10, 32'd3, 32'd4, 5'd6, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_idle_mul_ov", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        drive(4'd0, 32'd3, 32'd4, 5'd6, 1'b1);
        #1;
        chk("flush_idle_block", {31'd0, in_ready}, 32'd1);
        chk("flush_idle_add_ov", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;

        // Reset mid-multiply at MUL cycle 20.
        start_mul(4'd10, 32'hFFFFFFFF, 32'd2, 5'd5);
        for (int i = 1; i < 20; i++) @(negedge clk);
        rst = 1'b1;
        drive(4'd0, 32'd5, 32'd7, 5'd3, 1'b1);
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_rdy", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_y", alu_y, 32'd0);
        chk("rst_mid_rd", {27'd0, rd_out}, 32'd0);
        chk("rst_mid_rw", {31'd0, regwrite_out}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        notrdy = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (out_valid) pulses++;
            if (!in_ready) notrdy++;
            @(negedge clk);
        end
        chk("rst_mid_pulses", pulses, 0);
        chk("rst_mid_notrdy", notrdy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
